seven_seg_scroller: RTL

Registered, parametrised seven-segment display driver for the board's HEX displays. It shows a word wider than the display count, such as a 128-bit AES block, by scrolling a NUM_DIGITS-wide window of hex nibbles across it. The window advances on a manual step pulse or on an internal auto-advance timer. It sits between the AES datapath result register and the board HEX outputs, and supports full hex glyphs or decimal-only glyphs.

---
 rtl/seven_seg_pkg.sv | 53 +++++
 rtl/seven_seg_glyph.sv | 16 +
 rtl/seven_seg_scroller.sv | 102 ++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Glyph table and nibble-to-segment helper for the seven-segment scroller.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package seven_seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // In decimal-only mode the letter glyphs are blanked rather than
    // mis-rendered as digits.
    function automatic logic [6:0] nib_to_glyph(input logic [3:0] nibble, input logic hex_en);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = GLYPH_A;
            4'hB:    seg = GLYPH_B;
            4'hC:    seg = GLYPH_C;
            4'hD:    seg = GLYPH_D;
            4'hE:    seg = GLYPH_E;
            default: seg = GLYPH_F;
        endcase
        if (!hex_en && (nibble > 4'h9)) begin
            seg = GLYPH_BLANK;
        end
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Purpose: decode one hex nibble into an active-low seven-segment glyph.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports: i_nibble (4-bit value), o_seg (segments {g..a}, active-low).
module seven_seg_glyph
    import seven_seg_pkg::*;
#(
    parameter int HEX_EN = 1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = nib_to_glyph(i_nibble, HEX_EN != 0);

endmodule

// File: rtl/seven_seg_scroller.sv
// Purpose: scroll a NUM_DIGITS-wide window of hex nibbles across a wide word.
// Latency: HEX/win_pos update one cycle after the edge that changes shadow or position.
// Backpressure: none; load/step are single-cycle pulses, always accepted.
// Ports: clk, rst (sync, active-high), data_in/load (capture word),
//        step (manual advance), auto_en (timer advance), HEX (segments,
//        digit k at [7k+6:7k], leftmost = NUM_DIGITS-1), win_pos (window position).
module seven_seg_scroller
    import seven_seg_pkg::*;
#(
    parameter  int DATA_W     = 128,
    parameter  int NUM_DIGITS = 6,
    parameter  int STEP_DIV   = 25_000_000,
    parameter  int HEX_EN     = 1,
    localparam int NIB        = DATA_W / 4,
    localparam int PW         = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    load,
    input  logic                    step,
    input  logic                    auto_en,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [PW-1:0]           win_pos
);

    localparam int PMAX = NIB - NUM_DIGITS;
    localparam int CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int IW   = $clog2(DATA_W);

    localparam logic [CW-1:0] PRESC_LAST = CW'(STEP_DIV - 1);
    localparam logic [PW-1:0] P_LAST     = PW'(PMAX);

    logic [DATA_W-1:0]       r_shadow;
    logic [PW-1:0]           r_p;
    logic [CW-1:0]           r_presc;
    logic                    r_loaded;
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic [PW-1:0]           r_win_pos;

    logic                    w_tick;
    logic                    w_adv;
    logic [7*NUM_DIGITS-1:0] w_seg;

    // Timer tick; load priority is applied in the sequential block.
    assign w_tick = auto_en && (r_presc == PRESC_LAST);
    // Nothing advances before the first load so the blank display stays at p=0.
    assign w_adv  = r_loaded && (step || w_tick);

    // Digit k shows nibble index PMAX - p + k; base stays within the word
    // because p never exceeds PMAX.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [IW-1:0] w_base;
        logic [3:0]    w_nib;

        assign w_base = IW'((PMAX + k - int'(r_p)) * 4);
        assign w_nib  = r_shadow[w_base +: 4];

        seven_seg_glyph #(
            .HEX_EN (HEX_EN)
        ) u_glyph (
            .i_nibble (w_nib),
            .o_seg    (w_seg[7*k +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_p       <= '0;
            r_presc   <= '0;
            r_loaded  <= 1'b0;
            r_hex     <= '1;
            r_win_pos <= '0;
        end else begin
            if (load) begin
                r_shadow <= data_in;
                r_loaded <= 1'b1;
                r_p      <= '0;
                r_presc  <= '0;
            end else begin
                // Prescaler runs whenever auto_en is high, even before the
                // first load; manual steps never disturb it.
                if (!auto_en || w_tick) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
                // With PMAX = 0 the wrap keeps p pinned at 0.
                if (w_adv) begin
                    r_p <= (r_p == P_LAST) ? '0 : r_p + 1'b1;
                end
            end
            r_win_pos <= r_p;
            r_hex     <= r_loaded ? w_seg : '1;
        end
    end

    assign HEX     = r_hex;
    assign win_pos = r_win_pos;

endmodule
